// File: rtl/uart_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// parametrised UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO buffering words between the producer port and the UART
// serialiser. Full pushes and empty pops are ignored.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_level,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("uart_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input into a FIFO, then a
// start/data/parity/stop serialiser driving a registered tx line.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int  CLK_HZ     = 12000000,
    parameter int  BAUD       = 115200,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1,
    parameter int  FIFO_DEPTH = 16,
    localparam int LW         = clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [LW-1:0]        fifo_level
);

    localparam int             DIV       = calc_div(CLK_HZ, BAUD);
    localparam int             CW        = clog2(DIV);
    localparam int             BW        = clog2(DATA_BITS);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(DIV - 1);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic           LAST_STOP = (STOP_BITS == 2);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_tx_param: clocks per bit must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_par_check
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    state_t               r_state;
    logic [CW-1:0]        r_baud_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_stop_done;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_data;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_level (fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign in_ready    = !w_fifo_full;
    assign w_push      = in_valid && in_ready;
    assign w_bit_end   = (r_baud_cnt == LAST_CNT);
    assign w_stop_done = (r_state == ST_STOP) && w_bit_end && (r_stop_idx == LAST_STOP);
    // Pop from idle, or at the end of the last stop bit for gap-free frames.
    assign w_pop       = !w_fifo_empty && ((r_state == ST_IDLE) || w_stop_done);
    assign busy        = (r_state != ST_IDLE) || !w_fifo_empty;
    assign tx          = r_tx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_baud_cnt <= (r_state == ST_IDLE || w_bit_end) ? '0 : r_baud_cnt + CW'(1);
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_fifo_data;
                        r_parity <= parity_bit(w_fifo_data);
                        r_tx     <= 1'b0;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_BIT) begin
                            if (PARITY != PARITY_NONE) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                                r_state    <= ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == LAST_STOP) begin
                            if (w_pop) begin
                                r_shift  <= w_fifo_data;
                                r_parity <= parity_bit(w_fifo_data);
                                r_tx     <= 1'b0;
                                r_state  <= ST_START;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: several parameterisations checked against a
// frame-level line model, plus burst, reset and randomized traffic.
module tb_uart_tx_param;

    localparam int NI = 6;

    typedef struct {
        int         sel;
        logic [8:0] word;
        int         len;
        int         par_bit;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] vld_v;
    logic [NI-1:0] rdy_v;
    logic [NI-1:0] tx_v;
    logic [NI-1:0] busy_v;
    logic [7:0]    d0, d1, d2, d3;
    logic [4:0]    d4;
    logic [6:0]    d5;
    logic [4:0]    lvl0, lvl1, lvl2, lvl3, lvl4;
    logic [2:0]    lvl5;

    int cdiv   [NI] = '{104, 104, 104, 104, 104, 4};
    int cdbits [NI] = '{8, 8, 8, 8, 5, 7};
    int cpar   [NI] = '{0, 2, 1, 0, 0, 1};
    int cstop  [NI] = '{1, 1, 1, 2, 1, 2};

    int         checks = 0;
    int         errors = 0;
    logic       cap_par;
    logic [8:0] q [$];
    bit         drv_done;
    bit         acc;
    bit         seen_full;
    int         accepted;
    int         rdy_bad;
    int         nfr;
    logic [8:0] cur;

    always #5 clk = ~clk;

    uart_tx_param u0 (.clk(clk), .reset(reset), .in_data(d0), .in_valid(vld_v[0]), .in_ready(rdy_v[0]),
                      .tx(tx_v[0]), .busy(busy_v[0]), .fifo_level(lvl0));
    uart_tx_param #(.PARITY(2)) u1 (.clk(clk), .reset(reset), .in_data(d1), .in_valid(vld_v[1]), .in_ready(rdy_v[1]),
                      .tx(tx_v[1]), .busy(busy_v[1]), .fifo_level(lvl1));
    uart_tx_param #(.PARITY(1)) u2 (.clk(clk), .reset(reset), .in_data(d2), .in_valid(vld_v[2]), .in_ready(rdy_v[2]),
                      .tx(tx_v[2]), .busy(busy_v[2]), .fifo_level(lvl2));
    uart_tx_param #(.STOP_BITS(2)) u3 (.clk(clk), .reset(reset), .in_data(d3), .in_valid(vld_v[3]), .in_ready(rdy_v[3]),
                      .tx(tx_v[3]), .busy(busy_v[3]), .fifo_level(lvl3));
    uart_tx_param #(.DATA_BITS(5)) u4 (.clk(clk), .reset(reset), .in_data(d4), .in_valid(vld_v[4]), .in_ready(rdy_v[4]),
                      .tx(tx_v[4]), .busy(busy_v[4]), .fifo_level(lvl4));
    uart_tx_param #(.BAUD(3000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u5 (
                      .clk(clk), .reset(reset), .in_data(d5), .in_valid(vld_v[5]), .in_ready(rdy_v[5]),
                      .tx(tx_v[5]), .busy(busy_v[5]), .fifo_level(lvl5));

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int lvl(input int s);
        case (s)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            2:       return int'(lvl2);
            3:       return int'(lvl3);
            4:       return int'(lvl4);
            default: return int'(lvl5);
        endcase
    endfunction

    // Line value of frame bit j: start, data LSB first, optional parity, stop(s).
    function automatic logic exp_bit(input int s, input logic [8:0] w, input int j);
        logic [8:0] m;
        int         ones;
        m    = w & ((9'h1 << cdbits[s]) - 9'h1);
        ones = $countones(m);
        if (j == 0) return 1'b0;
        if (j <= cdbits[s]) return m[j-1];
        if (cpar[s] != 0 && j == cdbits[s] + 1) return (cpar[s] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    function automatic int frame_len(input int s);
        return (1 + cdbits[s] + ((cpar[s] != 0) ? 1 : 0) + cstop[s]) * cdiv[s];
    endfunction

    task automatic set_data(input int s, input logic [8:0] w);
        case (s)
            0:       d0 = w[7:0];
            1:       d1 = w[7:0];
            2:       d2 = w[7:0];
            3:       d3 = w[7:0];
            4:       d4 = w[4:0];
            default: d5 = w[6:0];
        endcase
    endtask

    task automatic push1(input int s, input logic [8:0] w);
        set_data(s, w);
        vld_v[s] = 1'b1;
        @(negedge clk);
        vld_v[s] = 1'b0;
    endtask

    // Called at a negedge; waits for the start bit, then checks every clock of
    // the frame and returns at the negedge after its last clock.
    task automatic check_frame(input int s, input logic [8:0] w, input int len, input int maxwait,
                               input string nm, output int waited);
        int   bad_k;
        logic bad_tx;
        logic bad_busy;
        logic bad_e;
        logic e;
        waited   = 0;
        bad_tx   = 1'b0;
        bad_busy = 1'b0;
        bad_e    = 1'b0;
        while (tx_v[s] === 1'b1 && waited < maxwait) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx_v[s] !== 1'b0) begin
            errors++;
            $display("FAIL %s start: tx=%b after %0d cycles, expected start bit", nm, tx_v[s], waited);
            return;
        end
        bad_k = -1;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_bit(s, w, k / cdiv[s]);
            if (cpar[s] != 0 && k == (1 + cdbits[s]) * cdiv[s] + cdiv[s] / 2) cap_par = tx_v[s];
            if (bad_k < 0 && (tx_v[s] !== e || busy_v[s] !== 1'b1)) begin
                bad_k    = k;
                bad_tx   = tx_v[s];
                bad_busy = busy_v[s];
                bad_e    = e;
            end
        end
        checks++;
        if (bad_k >= 0) begin
            errors++;
            $display("FAIL %s frame word %h: clock %0d tx=%b busy=%b, expected tx=%b busy=1",
                     nm, w, bad_k, bad_tx, bad_busy, bad_e);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs [4];
        int         wt;
        logic [8:0] wd;

        reset = 1'b0;
        vld_v = '0;
        for (int s = 0; s < NI; s++) set_data(s, 9'h0);
        vecs[0] = '{0, 9'h055, 1040, -1};
        vecs[1] = '{1, 9'h007, 1144, 1};
        vecs[2] = '{2, 9'h007, 1144, 0};
        vecs[3] = '{4, 9'h1FF, 728, -1};

        repeat (3) @(negedge clk);
        for (int s = 0; s < NI; s++) begin
            chk($sformatf("reset tx u%0d", s), int'(tx_v[s]), 1);
            chk($sformatf("reset in_ready u%0d", s), int'(rdy_v[s]), 1);
            chk($sformatf("reset busy u%0d", s), int'(busy_v[s]), 0);
            chk($sformatf("reset level u%0d", s), lvl(s), 0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames across parameterisations
        for (int i = 0; i < 4; i++) begin
            push1(vecs[i].sel, vecs[i].word);
            check_frame(vecs[i].sel, vecs[i].word, vecs[i].len, 8, $sformatf("vec%0d", i), wt);
            chk($sformatf("vec%0d latency", i), wt, 1);
            if (vecs[i].par_bit >= 0) chk($sformatf("vec%0d parity bit", i), int'(cap_par), vecs[i].par_bit);
            chk($sformatf("vec%0d busy after", i), int'(busy_v[vecs[i].sel]), 0);
            chk($sformatf("vec%0d tx idle after", i), int'(tx_v[vecs[i].sel]), 1);
        end

        // Two stop bits, back-to-back frames with no gap
        set_data(3, 9'h0A3);
        vld_v[3] = 1'b1;
        @(negedge clk);
        set_data(3, 9'h03C);
        @(negedge clk);
        vld_v[3] = 1'b0;
        check_frame(3, 9'h0A3, frame_len(3), 0, "b2b first", wt);
        check_frame(3, 9'h03C, frame_len(3), 0, "b2b second", wt);
        chk("b2b busy after", int'(busy_v[3]), 0);

        // Burst with in_valid held high from idle
        q.delete();
        accepted  = 0;
        seen_full = 1'b0;
        cur       = 9'h010;
        fork
            begin
                set_data(0, cur);
                vld_v[0] = 1'b1;
                for (int c = 0; c < 40; c++) begin
                    acc = rdy_v[0];
                    if (acc) begin
                        q.push_back(cur);
                        accepted++;
                    end else if (!seen_full) begin
                        seen_full = 1'b1;
                        chk("burst level when in_ready low", lvl(0), 16);
                    end
                    @(negedge clk);
                    if (acc) begin
                        cur = cur + 9'h1;
                        set_data(0, cur);
                    end
                end
                vld_v[0] = 1'b0;
                chk("burst accepted words", accepted, 17);
                chk("burst level after", lvl(0), 16);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    for (int g = 0; g < 100 && q.size() == 0; g++) @(negedge clk);
                    if (q.size() == 0) begin
                        chk("burst word available", 0, 1);
                        break;
                    end
                    wd = q.pop_front();
                    check_frame(0, wd, 1040, (i == 0) ? 8 : 0, $sformatf("burst%0d", i), wt);
                end
                chk("burst busy after", int'(busy_v[0]), 0);
            end
        join

        // Reset during data bit 3 with words queued
        vld_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_data(0, 9'h031 + 9'(k));
            @(negedge clk);
        end
        vld_v[0] = 1'b0;
        repeat (4 * 104 + 50 - 3) @(negedge clk);
        chk("tx in data bit 3", int'(tx_v[0]), int'(exp_bit(0, 9'h031, 4)));
        chk("level before reset", lvl(0), 4);
        reset = 1'b0;
        #1;
        chk("mid-frame reset tx", int'(tx_v[0]), 1);
        chk("mid-frame reset level", lvl(0), 0);
        chk("mid-frame reset busy", int'(busy_v[0]), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        push1(0, 9'h0F0);
        check_frame(0, 9'h0F0, 1040, 8, "after reset", wt);
        chk("after reset latency", wt, 1);
        chk("after reset busy", int'(busy_v[0]), 0);
        repeat (20) @(negedge clk);
        chk("no resume tx", int'(tx_v[0]), 1);

        // Randomized traffic on the fast instance
        q.delete();
        drv_done = 1'b0;
        rdy_bad  = 0;
        nfr      = 0;
        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    vld_v[5] = ($urandom_range(0, 2) == 0);
                    cur      = 9'($urandom_range(0, 511));
                    set_data(5, cur);
                    if (rdy_v[5] !== (lvl(5) != 4)) rdy_bad++;
                    if (vld_v[5] && rdy_v[5]) q.push_back(cur);
                    @(negedge clk);
                end
                vld_v[5] = 1'b0;
                drv_done = 1'b1;
                chk("random in_ready vs level", rdy_bad, 0);
            end
            begin
                while (!drv_done || q.size() > 0) begin
                    if (q.size() == 0) begin
                        @(negedge clk);
                    end else begin
                        wd = q.pop_front();
                        check_frame(5, wd, frame_len(5), 200, "random", wt);
                        nfr++;
                    end
                end
                chk("random frames seen", int'(nfr > 0), 1);
                chk("random busy after", int'(busy_v[5]), 0);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter: a generalised successor of the fixed-format serial TX path used by uart_clock.
- Producers push words through a valid/ready port into an internal FIFO.
- The block serialises each word on tx with configurable baud, data width, parity and stop bits.
- It sits between any on-chip data source and the board UART pin, and is clocked at the 12 MHz system clock.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz
- BAUD, 115200, line rate in bit/s; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit (104 at defaults); elaboration error if DIV < 4
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, FIFO entries, power of two, minimum 2

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous active-low reset
- in_data, in, DATA_BITS, word to transmit
- in_valid, in, 1, in_data is valid
- in_ready, out, 1, FIFO can accept; a push occurs on an edge with in_valid && in_ready
- tx, out, 1, serial line, idle high
- busy, out, 1, high while state != IDLE or FIFO not empty
- fifo_level, out, $clog2(FIFO_DEPTH)+1, number of words currently in FIFO

Behaviour:
- Reset values (async, reset low): tx=1, in_ready=1, busy=0, fifo_level=0, state=IDLE, FIFO pointers and baud counter cleared, shift register 0. Reset release takes effect synchronously.
- FIFO:
  - in_ready = (fifo_level != FIFO_DEPTH).
  - A push with in_ready low is ignored (no overflow, no corruption).
  - Push and pop on the same edge leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
  - IDLE with FIFO non-empty: next edge pops the head into the shift register, tx=0, enters START, baud counter=0.
  - Each bit state lasts exactly DIV clocks; the counter runs 0..DIV-1, advancing on DIV-1.
  - DATA: LSB first, DATA_BITS bits; bit index counter 0..DATA_BITS-1.
  - PARITY (only if PARITY != 0): odd mode makes the total ones in data+parity odd; even mode makes it even.
  - STOP: tx=1 for STOP_BITS*DIV clocks.
- Back-to-back frames: at the end of STOP, if the FIFO is non-empty, pop and enter START on the same edge. There is no idle gap; the next start bit follows the last stop bit directly.
- Latency: a word pushed at edge N into an empty FIFO with the block idle gives tx low after edge N+1.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV clocks.
- tx is driven directly from a register (glitch-free).
- Reset mid-frame: tx returns high immediately, the FIFO is flushed, and the partial frame is discarded with no resume.
- Parameter changes require re-elaboration; there are no run-time mode changes.

Decomposition:
- Package uart_pkg holds:
  - the parity mode constants (PARITY_NONE/ODD/EVEN)
  - the state encoding typedef
  - the function computing DIV from CLK_HZ/BAUD
  - a clog2 helper
- Sub-module uart_fifo: a synchronous FIFO (width DATA_BITS, depth FIFO_DEPTH, async active-low reset, push/pop/level) that uart_tx_param instantiates.
- The serialiser FSM and baud counter stay in the top module.

Test Plan:
- Defaults, push 0x55 once: tx low for 104 clocks, then bits 1,0,1,0,1,0,1,0 at 104 clocks each, then high. The frame spans 1040 clocks; busy drops the cycle after the stop bit ends.
- PARITY=2, push 0x07: parity bit = 1. With PARITY=1, same word: parity bit = 0. Frame length is 1144 clocks in both cases.
- STOP_BITS=2, push 0xA3 then 0x3C back-to-back: consecutive start-bit falling edges are exactly 1144 clocks apart, with no gap.
- Hold in_valid high from idle with incrementing data: exactly 17 words are accepted (one popped into the shifter, 16 buffered). in_ready falls when fifo_level=16, and the 17 frames appear in order and continuous.
- Assert reset during data bit 3 with 5 words queued: tx=1 and fifo_level=0 immediately. After release, push 0xF0: a clean frame begins 1 clock later.
- DATA_BITS=5, push 0x1F with upper bits ignored: 5 data bits of 1, and the frame lasts 7*104 = 728 clocks.
